// File: rtl/play_cmd_ctrl.sv
// Player command controller: debounced command codes drive
// track select, play/pause state and saturating volume.
module play_cmd_ctrl #(
  parameter int CMD_W    = 4,
  parameter int N_SONG   = 9,
  parameter int VOL_W    = 4,
  parameter int VOL_MAX  = 15,
  parameter int VOL_INIT = 8,
  parameter int HOLD_CYC = 4,
  localparam int IDX_W   = $clog2(N_SONG + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [CMD_W-1:0]  cmd,
  output logic [N_SONG-1:0] song_onehot,
  output logic [IDX_W-1:0]  song_idx,
  output logic              playing,
  output logic [VOL_W-1:0]  vol,
  output logic              song_start,
  output logic              cmd_ack,
  output logic              cmd_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_PAUSE
  } state_e;

  localparam logic [3:0] HOLD = 4'(HOLD_CYC);

  localparam logic [CMD_W-1:0] C_NS  = CMD_W'(N_SONG);
  localparam logic [CMD_W-1:0] C_RES = CMD_W'(N_SONG + 1);
  localparam logic [CMD_W-1:0] C_PAU = CMD_W'(N_SONG + 2);
  localparam logic [CMD_W-1:0] C_VUP = CMD_W'(N_SONG + 3);
  localparam logic [CMD_W-1:0] C_VDN = CMD_W'(N_SONG + 4);
  localparam logic [CMD_W-1:0] C_NXT = CMD_W'(N_SONG + 5);
  localparam logic [CMD_W-1:0] C_PRV = CMD_W'(N_SONG + 6);

  localparam logic [IDX_W-1:0] I_NS  = IDX_W'(N_SONG);
  localparam logic [IDX_W-1:0] I_ONE = IDX_W'(1);
  localparam logic [VOL_W-1:0] V_MAX = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0] V_INI = VOL_W'(VOL_INIT);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_SONG-1:0]  oh_q, oh_d;
  logic [VOL_W-1:0]   vol_q, vol_d;
  logic               play_q, play_d;
  logic               start_q, start_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;

  logic [3:0]         cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic [CMD_W-1:0]   prev_q, prev_d;
  logic               live, same, arm_eff, accept;
  logic               is_sel;

  // Stability counter: run length of one nonzero code, one-shot accept.
  always_comb begin
    cnt_d   = '0;
    prev_d  = '0;
    arm_eff = 1'b1;
    live    = cmd_valid && (cmd != '0);
    same    = live && (cmd == prev_q) && (cnt_q != '0);
    if (live) begin
      prev_d = cmd;
      if (same) begin
        arm_eff = armed_q;
        cnt_d   = (cnt_q == HOLD) ? cnt_q : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
    end
    accept  = arm_eff && (cnt_d == HOLD);
    armed_d = arm_eff && !accept;
  end

  // Stability registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
      prev_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      prev_q  <= prev_d;
    end
  end

  // Next state, track, volume and pulses for an accepted command.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vol_d   = vol_q;
    start_d = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    is_sel  = (cmd != '0) && (cmd <= C_NS);
    if (accept) begin
      ack_d = 1'b1;
      unique case (1'b1)
        is_sel: begin
          idx_d   = IDX_W'(cmd);
          state_d = S_PLAY;
          start_d = 1'b1;
        end
        cmd == C_RES: begin
          if (state_q == S_PAUSE) state_d = S_PLAY;
        end
        cmd == C_PAU: begin
          if (state_q == S_PLAY) state_d = S_PAUSE;
        end
        cmd == C_VUP: begin
          if (vol_q != V_MAX) vol_d = vol_q + 1'b1;
        end
        cmd == C_VDN: begin
          if (vol_q != '0) vol_d = vol_q - 1'b1;
        end
        cmd == C_NXT: begin
          idx_d   = (idx_q == I_NS) ? I_ONE : idx_q + 1'b1;
          state_d = S_PLAY;
          start_d = 1'b1;
        end
        cmd == C_PRV: begin
          idx_d   = (idx_q <= I_ONE) ? I_NS : idx_q - 1'b1;
          state_d = S_PLAY;
          start_d = 1'b1;
        end
        default: begin
          ack_d = 1'b0;
          err_d = 1'b1;
        end
      endcase
    end
    oh_d = '0;
    for (int i = 0; i < N_SONG; i++) begin
      oh_d[i] = (idx_d == IDX_W'(i + 1));
    end
    play_d = (state_d == S_PLAY);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      oh_q    <= '0;
      vol_q   <= V_INI;
      play_q  <= 1'b0;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      vol_q   <= vol_d;
      play_q  <= play_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign song_onehot = oh_q;
  assign song_idx    = idx_q;
  assign playing     = play_q;
  assign vol         = vol_q;
  assign song_start  = start_q;
  assign cmd_ack     = ack_q;
  assign cmd_err     = err_q;

endmodule
